// File: rtl/asm_pkg.sv
// Shared definitions for the alphabet-set multiplier (ASM) operand path:
// the alphabet codes, the nibble width, the per-nibble decode record and the sequencer states.
package asm_pkg;

  localparam int NIBBLE_WIDTH = 4;

  localparam logic [1:0] ALPH_1 = 2'b00;
  localparam logic [1:0] ALPH_3 = 2'b01;
  localparam logic [1:0] ALPH_5 = 2'b10;
  localparam logic [1:0] ALPH_7 = 2'b11;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] sl;
    logic       zero;
    logic       inexact;
  } nib_dec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAR,
    ST_SER
  } seq_state_e;

endpackage

// File: rtl/asm_nibble_decode.sv
// Combinational decode of one 4-bit multiplier nibble into alphabet select and left shift.
module asm_nibble_decode
  import asm_pkg::*;
(
  input  logic [NIBBLE_WIDTH-1:0] nibble,
  output nib_dec_t                dec
);

  always_comb begin
    dec.sel     = ALPH_1;
    dec.sl      = 2'd0;
    dec.zero    = 1'b0;
    // Odd values above 8 have no exact alphabet form; they take the decode of v-1.
    dec.inexact = nibble[3] & nibble[0];
    case (nibble)
      4'h0:        dec.zero = 1'b1;
      4'h2:        dec.sl   = 2'd1;
      4'h3:        dec.sel  = ALPH_3;
      4'h4:        dec.sl   = 2'd2;
      4'h5:        dec.sel  = ALPH_5;
      4'h6:        begin dec.sel = ALPH_3; dec.sl = 2'd1; end
      4'h7:        dec.sel  = ALPH_7;
      4'h8, 4'h9:  dec.sl   = 2'd3;
      4'hA, 4'hB:  begin dec.sel = ALPH_5; dec.sl = 2'd1; end
      4'hC, 4'hD:  begin dec.sel = ALPH_3; dec.sl = 2'd2; end
      4'hE, 4'hF:  begin dec.sel = ALPH_7; dec.sl = 2'd1; end
      default:     ;
    endcase
  end

endmodule

// File: rtl/asm_operand_sequencer.sv
// Handshaked ASM operand sequencer: decodes all nibbles on accept, then emits one parallel
// beat or a zero-skipping serial stream of non-zero nibbles.
module asm_operand_sequencer
  import asm_pkg::*;
#(
  parameter  int LOG2_WIDTH = 4,
  localparam int WIDTH      = 1 << LOG2_WIDTH,
  localparam int NIBBLES    = WIDTH / NIBBLE_WIDTH,
  localparam int IDX_W      = (LOG2_WIDTH > 3) ? (LOG2_WIDTH - 2) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operand,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NIBBLES-1:0] sel,
  output logic [2*NIBBLES-1:0] sl,
  output logic [NIBBLES-1:0]   zero_mask,
  output logic [NIBBLES-1:0]   inexact_mask,
  output logic [IDX_W-1:0]     nib_idx,
  output logic                 out_last
);

  nib_dec_t [NIBBLES-1:0] dec_in;
  logic     [NIBBLES-1:0] new_remain;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_dec
    asm_nibble_decode u_dec (
      .nibble (operand[NIBBLE_WIDTH*k +: NIBBLE_WIDTH]),
      .dec    (dec_in[k])
    );
    assign new_remain[k] = ~dec_in[k].zero;
  end

  seq_state_e             state_q, state_d;
  nib_dec_t [NIBBLES-1:0] lanes_q, lanes_d;
  logic [NIBBLES-1:0]     remain_q, remain_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [2*NIBBLES-1:0]   sel_q, sel_d;
  logic [2*NIBBLES-1:0]   sl_q, sl_d;
  logic [NIBBLES-1:0]     zero_q, zero_d;
  logic [NIBBLES-1:0]     inex_q, inex_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   last_q, last_d;

  nib_dec_t [NIBBLES-1:0] src_lanes;
  logic [NIBBLES-1:0]     cand;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_higher;

  // One selector serves both the first serial beat (fresh decode) and every following beat.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_lanes = dec_in;
      cand      = new_remain;
    end else begin
      src_lanes = lanes_q;
      cand      = remain_q & ~(NIBBLES'(1) << idx_q);
    end
  end

  always_comb begin
    logic found;
    found       = 1'b0;
    pick_idx    = '0;
    pick_higher = 1'b0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cand[i]) begin
        if (found) begin
          pick_higher = 1'b1;
        end else begin
          pick_idx = IDX_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    remain_d    = remain_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    sl_d        = sl_q;
    zero_d      = zero_q;
    inex_d      = inex_q;
    idx_d       = idx_q;
    last_d      = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          lanes_d     = dec_in;
          remain_d    = new_remain;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          if (!mode) begin
            state_d = ST_PAR;
            for (int unsigned k = 0; k < NIBBLES; k++) begin
              sel_d[2*k +: 2] = dec_in[k].sel;
              sl_d[2*k +: 2]  = dec_in[k].sl;
              zero_d[k]       = dec_in[k].zero;
              inex_d[k]       = dec_in[k].inexact;
            end
            idx_d  = '0;
            last_d = 1'b1;
          end else begin
            state_d = ST_SER;
            // All-zero operand: pick_idx stays 0 and lane 0 already decodes as zero.
            sel_d     = '0;
            sl_d      = '0;
            zero_d    = '0;
            inex_d    = '0;
            sel_d[1:0] = src_lanes[pick_idx].sel;
            sl_d[1:0]  = src_lanes[pick_idx].sl;
            zero_d[0]  = src_lanes[pick_idx].zero;
            inex_d[0]  = src_lanes[pick_idx].inexact;
            idx_d      = pick_idx;
            last_d     = ~pick_higher;
          end
        end
      end
      ST_PAR: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          sel_d       = '0;
          sl_d        = '0;
          zero_d      = '0;
          inex_d      = '0;
          idx_d       = '0;
          last_d      = 1'b0;
        end
      end
      ST_SER: begin
        if (out_ready) begin
          remain_d = cand;
          sel_d    = '0;
          sl_d     = '0;
          zero_d   = '0;
          inex_d   = '0;
          if (last_q) begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            idx_d       = '0;
            last_d      = 1'b0;
          end else begin
            sel_d[1:0] = src_lanes[pick_idx].sel;
            sl_d[1:0]  = src_lanes[pick_idx].sl;
            zero_d[0]  = src_lanes[pick_idx].zero;
            inex_d[0]  = src_lanes[pick_idx].inexact;
            idx_d      = pick_idx;
            last_d     = ~pick_higher;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lanes_q     <= '0;
      remain_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      sl_q        <= '0;
      zero_q      <= '0;
      inex_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      remain_q    <= remain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      sl_q        <= sl_d;
      zero_q      <= zero_d;
      inex_q      <= inex_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign sel          = sel_q;
  assign sl           = sl_q;
  assign zero_mask    = zero_q;
  assign inexact_mask = inex_q;
  assign nib_idx      = idx_q;
  assign out_last     = last_q;

endmodule

// File: tb/tb_asm_operand_sequencer.sv
// Randomized bench for asm_operand_sequencer (16-bit operand) against an arithmetic decode model.
module tb_asm_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] operand = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  sel;
  logic [7:0]  sl;
  logic [3:0]  zero_mask;
  logic [3:0]  inexact_mask;
  logic [1:0]  nib_idx;
  logic        out_last;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // {out_valid, in_ready, sel, sl, zero_mask, inexact_mask, nib_idx, out_last}
  logic [28:0] exp_q[$];

  asm_operand_sequencer #(.LOG2_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operand      (operand),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sel          (sel),
    .sl           (sl),
    .zero_mask    (zero_mask),
    .inexact_mask (inexact_mask),
    .nib_idx      (nib_idx),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] observed();
    return {out_valid, in_ready, sel, sl, zero_mask, inexact_mask, nib_idx, out_last};
  endfunction

  // Value v is value odd*2^shift; alphabet index is (odd-1)/2. Odd v>8 rounds down first.
  function automatic logic [5:0] model_dec(input int v);
    int u, sh, o;
    logic ix;
    ix = (v > 8) && (v % 2 == 1);
    u  = ix ? v - 1 : v;
    if (u == 0) return 6'b00_00_1_0;
    sh = 0;
    o  = u;
    while (o % 2 == 0) begin
      o  = o / 2;
      sh = sh + 1;
    end
    return {2'((o - 1) / 2), 2'(sh), 1'b0, ix};
  endfunction

  task automatic build_exp(input logic [15:0] op, input logic md);
    logic [7:0] s, h;
    logic [3:0] z, x;
    logic [5:0] d;
    int nz[$];
    exp_q.delete();
    if (!md) begin
      for (int k = 0; k < 4; k++) begin
        d = model_dec(int'((op >> (4 * k)) & 16'hF));
        s[2*k +: 2] = d[5:4];
        h[2*k +: 2] = d[3:2];
        z[k] = d[1];
        x[k] = d[0];
      end
      exp_q.push_back({1'b1, 1'b0, s, h, z, x, 2'd0, 1'b1});
    end else begin
      for (int k = 0; k < 4; k++)
        if (((op >> (4 * k)) & 16'hF) != 0) nz.push_back(k);
      if (nz.size() == 0)
        exp_q.push_back({1'b1, 1'b0, 8'h00, 8'h00, 4'b0001, 4'b0000, 2'd0, 1'b1});
      for (int j = 0; j < nz.size(); j++) begin
        d = model_dec(int'((op >> (4 * nz[j])) & 16'hF));
        exp_q.push_back({1'b1, 1'b0, {6'b0, d[5:4]}, {6'b0, d[3:2]}, 4'b0000,
                         {3'b0, d[0]}, 2'(nz[j]), (j == nz.size() - 1)});
      end
    end
  endtask

  // One operand transaction. stall_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic check_op(input logic [15:0] op, input logic md, input int stall_mode, input string tag);
    int budget, pat, stalls;
    logic rdy, done;
    logic [3:0] pat_bits;
    logic [28:0] e;
    pat_bits = 4'b1001;
    build_exp(op, md);
    budget = 0;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s ready_wait in_ready=%b required 1", tag, in_ready);
      miss_cnt++;
      return;
    end
    in_valid  = 1'b1;
    operand   = op;
    mode      = md;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pat = 0;
    for (int b = 0; b < exp_q.size(); b++) begin
      e = exp_q[b];
      done = 1'b0;
      stalls = 0;
      while (!done) begin
        vec_cnt++;
        if (observed() !== e) begin
          $display("FAIL %s beat%0d op=%h mode=%b got=%h required=%h", tag, b, op, md, observed(), e);
          miss_cnt++;
        end
        case (stall_mode)
          0:       rdy = 1'b1;
          1:       begin rdy = pat_bits[3 - (pat % 4)]; pat++; end
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (stalls >= 8) rdy = 1'b1;
        out_ready = rdy;
        in_valid  = 1'($urandom_range(0, 1));
        operand   = 16'($urandom);
        mode      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (rdy) done = 1'b1;
        else stalls++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL %s after_last valid,ready=%b required 01", tag, {out_valid, in_ready});
      miss_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (observed() !== {1'b0, 1'b1, 27'd0}) begin
      $display("FAIL reset got=%h required=%h", observed(), {1'b0, 1'b1, 27'd0});
      miss_cnt++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_parallel();
    check_op(16'h3C6A, 1'b0, 0, "par_3C6A");
    check_op(16'h0000, 1'b0, 0, "par_zero");
    check_op(16'hFFFF, 1'b0, 2, "par_FFFF");
  endtask

  task automatic test_inexact();
    logic [3:0] vals[4];
    vals = '{4'h9, 4'hB, 4'hD, 4'hF};
    for (int i = 0; i < 4; i++)
      check_op({12'h000, vals[i]}, 1'b0, 0, "inexact");
  endtask

  task automatic test_serial();
    check_op(16'h0507, 1'b1, 0, "ser_0507");
    check_op(16'h0000, 1'b1, 0, "ser_zero");
    check_op(16'hE000, 1'b1, 0, "ser_top");
  endtask

  task automatic test_backpressure();
    check_op(16'h1111, 1'b1, 1, "bp_1111");
    check_op(16'h3C6A, 1'b0, 1, "bp_par");
  endtask

  task automatic test_reset_mid();
    logic [28:0] e;
    build_exp(16'hFFFF, 1'b1);
    in_valid  = 1'b1;
    operand   = 16'hFFFF;
    mode      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      e = exp_q[b];
      vec_cnt++;
      if (observed() !== e) begin
        $display("FAIL rst_mid beat%0d got=%h required=%h", b, observed(), e);
        miss_cnt++;
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    vec_cnt++;
    if (observed() !== {1'b0, 1'b1, 27'd0}) begin
      $display("FAIL rst_mid_flush got=%h required=%h", observed(), {1'b0, 1'b1, 27'd0});
      miss_cnt++;
    end
    check_op(16'h0001, 1'b0, 0, "rst_mid_new");
  endtask

  task automatic test_random();
    logic [15:0] op;
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 4; k++)
        op[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      check_op(op, 1'($urandom_range(0, 1)), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_inexact();
    test_serial();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
